uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Four-requester round-robin scheduler feeding a single 8N1 UART transmitter.
// Arbitration happens only on baud ticks while idle or at the end of a stop bit.
module uart_tx_scheduler #(
  parameter int unsigned BAUD_DIV = 103
) (
  input  logic        CLKIN,
  input  logic        RESET,
  input  logic [3:0]  REQ,
  input  logic [31:0] DATA,
  output logic [3:0]  ACK,
  output logic        TX,
  output logic        BUSY,
  output logic [1:0]  GRANT
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned NREQ  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q;
  logic              tick_c;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        grant_d;
  logic              tx_d, busy_d;
  logic [3:0]        ack_d;
  logic              slot_c;
  logic              found_c;
  logic [1:0]        win_c;
  logic [1:0]        arb_idx_c;

  assign tick_c = (baud_q == CNT_W'(BAUD_DIV - 1));

  // Free-running bit-period counter
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      baud_q <= '0;
    end else if (tick_c) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_q + CNT_W'(1);
    end
  end

  // Round-robin search: scanning offsets high to low leaves the nearest one to ptr as winner
  always_comb begin
    found_c   = 1'b0;
    win_c     = ptr_q;
    arb_idx_c = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      arb_idx_c = ptr_q + 2'(i);
      if (REQ[arb_idx_c]) begin
        found_c = 1'b1;
        win_c   = arb_idx_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    grant_d = GRANT;
    tx_d    = TX;
    busy_d  = BUSY;
    ack_d   = '0;
    slot_c  = 1'b0;

    if (tick_c) begin
      unique case (state_q)
        ST_IDLE: slot_c = 1'b1;
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = 3'd0;
        end
        ST_DATA: begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
        ST_STOP: slot_c = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end

    // Grant straight from STOP into START keeps frames back-to-back
    if (slot_c) begin
      if (found_c) begin
        shreg_d = DATA[{win_c, 3'b000} +: 8];
        grant_d = win_c;
        ptr_d   = win_c + 2'd1;
        state_d = ST_START;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        ack_d   = 4'b0001 << win_c;
      end else begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      GRANT   <= '0;
      TX      <= 1'b1;
      BUSY    <= 1'b0;
      ACK     <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      GRANT   <= grant_d;
      TX      <= tx_d;
      BUSY    <= busy_d;
      ACK     <= ack_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (divider 103 and 2) share stimulus and are
// compared every cycle against a frame-age model, plus directed literal scenarios.
module tb_uart_tx_scheduler;

  localparam int BD0 = 103;
  localparam int BD1 = 2;

  logic             clk;
  logic             RESET;
  logic [3:0]       REQ;
  logic [31:0]      DATA;
  logic [1:0]       tx_v;
  logic [1:0]       busy_v;
  logic [1:0][3:0]  ack_v;
  logic [1:0][1:0]  grant_v;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  uart_tx_scheduler #(.BAUD_DIV(BD0)) u_div103 (
    .CLKIN(clk), .RESET(RESET), .REQ(REQ), .DATA(DATA),
    .ACK(ack_v[0]), .TX(tx_v[0]), .BUSY(busy_v[0]), .GRANT(grant_v[0])
  );

  uart_tx_scheduler #(.BAUD_DIV(BD1)) u_div2 (
    .CLKIN(clk), .RESET(RESET), .REQ(REQ), .DATA(DATA),
    .ACK(ack_v[1]), .TX(tx_v[1]), .BUSY(busy_v[1]), .GRANT(grant_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a frame is described by its age in cycles since the grant edge
  int         m_cnt  [2];
  int         m_age  [2];
  bit         m_busy [2];
  logic [1:0] m_ptr  [2];
  logic [1:0] m_grant[2];
  logic [3:0] m_ack  [2];
  logic [7:0] m_byte [2];

  function automatic int bd_of(input int d);
    return (d == 0) ? BD0 : BD1;
  endfunction

  function automatic logic exp_tx(input int d);
    int b;
    if (!m_busy[d]) return 1'b1;
    b = m_age[d] / bd_of(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[d][b-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    bit tick;
    bit got;
    int k;
    for (int d = 0; d < 2; d++) begin
      if (RESET) begin
        m_cnt[d] = 0; m_age[d] = 0; m_busy[d] = 0; m_ptr[d] = 2'd0;
        m_grant[d] = 2'd0; m_ack[d] = 4'd0; m_byte[d] = 8'd0;
      end else begin
        tick = ((m_cnt[d] % bd_of(d)) == bd_of(d) - 1);
        m_cnt[d] = m_cnt[d] + 1;
        m_ack[d] = 4'd0;
        if (m_busy[d]) m_age[d] = m_age[d] + 1;
        if (tick && (!m_busy[d] || m_age[d] == 10 * bd_of(d))) begin
          if (REQ != 4'd0) begin
            got = 0;
            for (int i = 0; i < 4; i++) begin
              k = (int'(m_ptr[d]) + i) % 4;
              if (!got && REQ[k]) begin
                got = 1;
                m_grant[d] = 2'(k);
                m_ptr[d]   = 2'((k + 1) % 4);
                m_byte[d]  = DATA[8*k +: 8];
                m_ack[d]   = 4'(1 << k);
                m_busy[d]  = 1;
                m_age[d]   = 0;
              end
            end
          end else begin
            m_busy[d] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("tx_dut%0d", d),    32'(tx_v[d]),    32'(exp_tx(d)));
        check($sformatf("busy_dut%0d", d),  32'(busy_v[d]),  32'(m_busy[d]));
        check($sformatf("ack_dut%0d", d),   32'(ack_v[d]),   32'(m_ack[d]));
        check($sformatf("grant_dut%0d", d), 32'(grant_v[d]), 32'(m_grant[d]));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b1;
    REQ   = 4'd0;
    @(negedge clk);
    started = 1;
    check("rst_tx",    32'(tx_v[0]),    32'd1);
    check("rst_busy",  32'(busy_v[0]),  32'd0);
    check("rst_ack",   32'(ack_v[0]),   32'd0);
    check("rst_grant", 32'(grant_v[0]), 32'd0);
    RESET = 1'b0;
  endtask

  task automatic wait_ack(input int d, input int budget, output int k, output int cyc);
    k = -1;
    cyc = 0;
    while (k < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 3; i >= 0; i--) if (ack_v[d][i]) k = i;
    end
    if (k < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  logic tx_hist [0:1099];
  int   exp_55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int   exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int   exp_rr [5]  = '{0, 1, 2, 3, 0};

  initial begin
    int k, cyc, busy_cnt, extra_ack, bad;
    RESET = 1'b1;
    REQ   = 4'd0;
    DATA  = 32'd0;

    // Single byte 0x55 on divider 103
    do_reset();
    REQ = 4'b0001; DATA = 32'h0000_0055;
    wait_ack(0, 200, k, cyc);
    REQ = 4'd0;
    check("single_k", 32'(k), 32'd0);
    check("single_first_tick", 32'(cyc), 32'd103);
    busy_cnt = 0; extra_ack = 0;
    for (int i = 0; i < 1100; i++) begin
      if (i > 0) @(negedge clk);
      tx_hist[i] = tx_v[0];
      if (busy_v[0]) busy_cnt++;
      if (i > 0 && ack_v[0] != 4'd0) extra_ack++;
    end
    for (int b = 0; b < 10; b++)
      check($sformatf("single_bit%0d", b), 32'(tx_hist[b*103+50]), 32'(exp_55[b]));
    check("single_busy_len", 32'(busy_cnt), 32'd1030);
    check("single_extra_ack", 32'(extra_ack), 32'd0);

    // Minimum divider, 0xA5 from requester 2
    do_reset();
    REQ = 4'b0100; DATA = 32'h00A5_0000;
    wait_ack(1, 50, k, cyc);
    REQ = 4'd0;
    check("div2_k", 32'(k), 32'd2);
    check("div2_first_tick", 32'(cyc), 32'd2);
    busy_cnt = 0; extra_ack = 0;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) @(negedge clk);
      tx_hist[i] = tx_v[1];
      if (busy_v[1]) busy_cnt++;
      if (i > 0 && ack_v[1] != 4'd0) extra_ack++;
    end
    for (int b = 0; b < 10; b++)
      check($sformatf("div2_bit%0d", b), 32'(tx_hist[2*b]), 32'(exp_a5[b]));
    check("div2_busy_len", 32'(busy_cnt), 32'd20);
    check("div2_extra_ack", 32'(extra_ack), 32'd0);

    // Round robin with all requests held
    do_reset();
    REQ = 4'b1111; DATA = 32'h4433_2211;
    for (int j = 0; j < 5; j++) begin
      wait_ack(0, 1200, k, cyc);
      check($sformatf("rr_grant%0d", j), 32'(grant_v[0]), 32'(exp_rr[j]));
      check($sformatf("rr_onehot%0d", j), 32'(ack_v[0]), 32'(1 << exp_rr[j]));
      if (j > 0) check($sformatf("rr_gap%0d", j), 32'(cyc), 32'd1030);
    end
    REQ = 4'd0;

    // Pointer fairness
    do_reset();
    REQ = 4'b0010;
    wait_ack(0, 200, k, cyc);
    check("fair_first", 32'(k), 32'd1);
    REQ = 4'b1010;
    wait_ack(0, 1200, k, cyc);
    check("fair_second", 32'(k), 32'd3);
    wait_ack(0, 1200, k, cyc);
    check("fair_third", 32'(k), 32'd1);
    REQ = 4'd0;

    // Mid-frame reset during data bit 4
    do_reset();
    REQ = 4'b0001; DATA = 32'h0000_00F0;
    wait_ack(0, 200, k, cyc);
    REQ = 4'd0;
    repeat (103 * 5 + 50) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    check("midrst_tx",   32'(tx_v[0]),   32'd1);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_ack",  32'(ack_v[0]),  32'd0);
    RESET = 1'b0;
    REQ = 4'b1111;
    wait_ack(0, 200, k, cyc);
    check("midrst_regrant", 32'(k), 32'd0);
    REQ = 4'd0;

    // Transient request between slots
    do_reset();
    repeat (20) @(negedge clk);
    REQ = 4'b0010;
    repeat (10) @(negedge clk);
    REQ = 4'd0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack_v[0] != 4'd0 || tx_v[0] != 1'b1 || busy_v[0] != 1'b0) bad++;
    end
    check("transient_ignored", 32'(bad), 32'd0);

    // Randomised traffic with occasional resets
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      if (RESET) RESET = 1'b0;
      else if ($urandom_range(0, 4999) == 0) RESET = 1'b1;
      for (int r = 0; r < 4; r++) begin
        if (REQ[r]) begin
          if (ack_v[0][r] && $urandom_range(0, 9) < 8) REQ[r] = 1'b0;
          else if ($urandom_range(0, 999) == 0) REQ[r] = 1'b0;
        end else if ($urandom_range(0, 299) == 0) begin
          DATA[8*r +: 8] = 8'($urandom);
          REQ[r] = 1'b1;
        end
      end
    end
    RESET = 1'b0;
    REQ = 4'd0;
    repeat (2100) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
